// File: rtl/fsk_tx_sequencer.sv
// FSK transmit sequencer: accepts bytes over valid/ready into a one-entry
// holding buffer, frames each byte as start(0) + 8 data bits LSB first +
// stop(1), and generates the sample strobe / phase index for the modulator
// LUT. Symbols only change at phase wrap so the waveform stays continuous.
module fsk_tx_sequencer #(
  parameter int   PHASE_W         = 5,
  parameter int   CLKS_PER_SAMPLE = 1,
  parameter logic IDLE_BIT        = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               sample_en,
  output logic [PHASE_W-1:0] phase_idx,
  output logic               symbol_bit,
  output logic               symbol_start,
  output logic               busy,
  output logic               frame_done
);

  localparam int DIV_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLKS_PER_SAMPLE - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = '1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       buf_data;
  logic [7:0]       shift;
  logic             boundary;
  logic             push;
  logic             load;

  // tx_ready doubles as the "holding buffer empty" flag
  assign boundary = sample_en && (phase_idx == PHASE_LAST);
  assign push     = tx_valid && tx_ready;
  assign load     = boundary && !tx_ready && ((state == IDLE) || (state == STOP));

  // Sample divider: strobe on the clk after div_cnt reaches its last count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt   <= '0;
      sample_en <= 1'b0;
    end else begin
      sample_en <= (div_cnt == DIV_LAST);
      div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  // Free-running phase index; natural wrap at SPS-1 marks the symbol boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_idx    <= '0;
      symbol_start <= 1'b0;
    end else begin
      symbol_start <= boundary;
      if (sample_en) begin
        phase_idx <= phase_idx + PHASE_W'(1);
      end
    end
  end

  // Byte storage (data path, not reset): capture on push, move to shifter on load
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data <= tx_data;
    end
    if (load) begin
      shift <= buf_data;
    end
  end

  // Frame state machine; advances only on symbol boundaries
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      symbol_bit <= IDLE_BIT;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      tx_ready   <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      if (push) begin
        tx_ready <= 1'b0;
      end
      if (boundary) begin
        case (state)
          IDLE: begin
            if (!tx_ready) begin
              tx_ready   <= 1'b1;
              symbol_bit <= 1'b0;
              busy       <= 1'b1;
              state      <= START;
            end else begin
              symbol_bit <= IDLE_BIT;
            end
          end
          START: begin
            symbol_bit <= shift[0];
            bit_cnt    <= 4'd1;
            state      <= DATA;
          end
          DATA: begin
            if (bit_cnt < 4'd8) begin
              symbol_bit <= shift[bit_cnt[2:0]];
              bit_cnt    <= bit_cnt + 4'd1;
            end else begin
              symbol_bit <= 1'b1;
              state      <= STOP;
            end
          end
          STOP: begin
            frame_done <= 1'b1;
            if (!tx_ready) begin
              // another byte waiting: go straight into its start symbol
              tx_ready   <= 1'b1;
              symbol_bit <= 1'b0;
              state      <= START;
            end else begin
              symbol_bit <= IDLE_BIT;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
